// File: rtl/sys_state_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sys_state_ctrl
// Brief    : JPEG core system state controller with fault classification,
//            watchdog/init timeouts and a sticky maskable interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module sys_state_ctrl #(
    parameter int INIT_TIMEOUT = 256,
    parameter int WDOG_TIMEOUT = 1024,
    parameter int CNT_WIDTH    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_enable,
    input  logic [3:0] cfg_mode,
    input  logic       cfg_intr_mask,
    input  logic       init_done,
    input  logic       busy,
    input  logic       parity_err,
    input  logic       fatal_err,
    input  logic       err_clear,
    output logic [2:0] state,
    output logic       init_start,
    output logic [3:0] mode_q,
    output logic [1:0] err_type,
    output logic       irq,
    output logic [7:0] err_count
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'b000,
        S_INIT     = 3'b001,
        S_ACTIVE   = 3'b010,
        S_ERROR    = 3'b011,
        S_SHUTDOWN = 3'b100
    } state_t;

    typedef enum logic [1:0] {
        E_NONE    = 2'b00,
        E_PARITY  = 2'b01,
        E_TIMEOUT = 2'b10,
        E_FATAL   = 2'b11
    } err_t;

    localparam logic [CNT_WIDTH-1:0] C_INIT_LAST = CNT_WIDTH'(INIT_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] C_WDOG_LAST = CNT_WIDTH'(WDOG_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] C_CNT_ONE   = CNT_WIDTH'(1);

    state_t               r_state,      w_state_nxt;
    err_t                 r_err_type,   w_err_type_nxt;
    logic [CNT_WIDTH-1:0] r_cnt,        w_cnt_nxt;
    logic [3:0]           r_mode,       w_mode_nxt;
    logic [7:0]           r_err_count,  w_err_count_nxt;
    logic                 r_irq,        w_irq_nxt;
    logic                 r_init_start, w_init_start_nxt;
    err_t                 w_fault;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_err_type   <= E_NONE;
            r_cnt        <= '0;
            r_mode       <= 4'd0;
            r_err_count  <= 8'd0;
            r_irq        <= 1'b0;
            r_init_start <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_err_type   <= w_err_type_nxt;
            r_cnt        <= w_cnt_nxt;
            r_mode       <= w_mode_nxt;
            r_err_count  <= w_err_count_nxt;
            r_irq        <= w_irq_nxt;
            r_init_start <= w_init_start_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_err_type_nxt   = r_err_type;
        w_cnt_nxt        = r_cnt;
        w_mode_nxt       = r_mode;
        w_err_count_nxt  = r_err_count;
        w_irq_nxt        = r_irq;
        w_init_start_nxt = 1'b0;
        w_fault          = E_NONE;

        // Fault checks come first in each state so they outrank normal transitions.
        case (r_state)
            S_IDLE: begin
                if (fatal_err) begin
                    w_fault = E_FATAL;
                end else if (cfg_enable) begin
                    w_state_nxt      = S_INIT;
                    w_init_start_nxt = 1'b1;
                    w_mode_nxt       = cfg_mode;
                    w_cnt_nxt        = '0;
                end
            end
            S_INIT: begin
                if (fatal_err) begin
                    w_fault = E_FATAL;
                end else if (parity_err) begin
                    w_fault = E_PARITY;
                end else if (init_done) begin
                    w_state_nxt = S_ACTIVE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == C_INIT_LAST) begin
                    w_fault = E_TIMEOUT;
                end else begin
                    w_cnt_nxt = r_cnt + C_CNT_ONE;
                end
            end
            S_ACTIVE: begin
                if (fatal_err) begin
                    w_fault = E_FATAL;
                end else if (parity_err) begin
                    w_fault = E_PARITY;
                end else if (!busy && (r_cnt == C_WDOG_LAST)) begin
                    w_fault = E_TIMEOUT;
                end else begin
                    w_cnt_nxt = busy ? '0 : (r_cnt + C_CNT_ONE);
                    if (!cfg_enable) begin
                        w_state_nxt = S_SHUTDOWN;
                    end
                end
            end
            S_SHUTDOWN: begin
                if (fatal_err) begin
                    w_fault = E_FATAL;
                end else if (!busy) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            S_ERROR: begin
                // A fatal fault here only upgrades the type; the entry count is unchanged.
                if (fatal_err) begin
                    w_err_type_nxt = E_FATAL;
                    w_irq_nxt      = r_irq | ~cfg_intr_mask;
                end else if (err_clear && (r_err_type != E_FATAL)) begin
                    w_state_nxt    = S_IDLE;
                    w_err_type_nxt = E_NONE;
                    w_irq_nxt      = 1'b0;
                    w_cnt_nxt      = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_fault != E_NONE) begin
            w_state_nxt     = S_ERROR;
            w_err_type_nxt  = w_fault;
            w_err_count_nxt = (r_err_count == 8'hFF) ? r_err_count : (r_err_count + 8'd1);
            w_irq_nxt       = r_irq | ~cfg_intr_mask;
        end
    end

    assign state      = r_state;
    assign init_start = r_init_start;
    assign mode_q     = r_mode;
    assign err_type   = r_err_type;
    assign irq        = r_irq;
    assign err_count  = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_sys_state_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sys_state_ctrl
// Brief    : Directed scenarios plus randomized run against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sys_state_ctrl;

    localparam int INIT_TIMEOUT = 256;
    localparam int WDOG_TIMEOUT = 1024;
    localparam int ST_IDLE = 0, ST_INIT = 1, ST_ACTIVE = 2, ST_ERROR = 3, ST_SHUTDOWN = 4;
    localparam int ER_NONE = 0, ER_PARITY = 1, ER_TIMEOUT = 2, ER_FATAL = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_enable = 1'b0;
    logic [3:0] cfg_mode = 4'd0;
    logic       cfg_intr_mask = 1'b0;
    logic       init_done = 1'b0;
    logic       busy = 1'b0;
    logic       parity_err = 1'b0;
    logic       fatal_err = 1'b0;
    logic       err_clear = 1'b0;
    logic [2:0] state;
    logic       init_start;
    logic [3:0] mode_q;
    logic [1:0] err_type;
    logic       irq;
    logic [7:0] err_count;

    sys_state_ctrl #(
        .INIT_TIMEOUT(INIT_TIMEOUT),
        .WDOG_TIMEOUT(WDOG_TIMEOUT),
        .CNT_WIDTH   (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_enable   (cfg_enable),
        .cfg_mode     (cfg_mode),
        .cfg_intr_mask(cfg_intr_mask),
        .init_done    (init_done),
        .busy         (busy),
        .parity_err   (parity_err),
        .fatal_err    (fatal_err),
        .err_clear    (err_clear),
        .state        (state),
        .init_start   (init_start),
        .mode_q       (mode_q),
        .err_type     (err_type),
        .irq          (irq),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Behavioural model: plain integers, one call per rising edge.
    int m_state, m_wait, m_err_type, m_irq, m_err_count, m_mode, m_init_start;

    wire [18:0] dut_vec = {state, init_start, mode_q, err_type, irq, err_count};

    function automatic logic [18:0] model_vec();
        return {m_state[2:0], m_init_start[0], m_mode[3:0], m_err_type[1:0], m_irq[0], m_err_count[7:0]};
    endfunction

    task automatic model_reset();
        m_state = ST_IDLE; m_wait = 0; m_err_type = ER_NONE; m_irq = 0;
        m_err_count = 0; m_mode = 0; m_init_start = 0;
    endtask

    task automatic model_step();
        int fault;
        m_init_start = 0;
        if (m_state == ST_ERROR) begin
            if (fatal_err) begin
                m_err_type = ER_FATAL;
                if (!cfg_intr_mask) m_irq = 1;
            end else if (err_clear && m_err_type != ER_FATAL) begin
                m_state = ST_IDLE; m_err_type = ER_NONE; m_irq = 0; m_wait = 0;
            end
        end else begin
            fault = ER_NONE;
            if (fatal_err) fault = ER_FATAL;
            else if (parity_err && (m_state == ST_INIT || m_state == ST_ACTIVE)) fault = ER_PARITY;
            else if (m_state == ST_INIT && !init_done && m_wait == INIT_TIMEOUT - 1) fault = ER_TIMEOUT;
            else if (m_state == ST_ACTIVE && !busy && m_wait == WDOG_TIMEOUT - 1) fault = ER_TIMEOUT;
            if (fault != ER_NONE) begin
                m_state = ST_ERROR;
                m_err_type = fault;
                m_err_count = (m_err_count < 255) ? m_err_count + 1 : 255;
                if (!cfg_intr_mask) m_irq = 1;
            end else if (m_state == ST_IDLE) begin
                if (cfg_enable) begin
                    m_state = ST_INIT; m_init_start = 1; m_mode = int'(cfg_mode); m_wait = 0;
                end
            end else if (m_state == ST_INIT) begin
                if (init_done) begin m_state = ST_ACTIVE; m_wait = 0; end
                else m_wait = m_wait + 1;
            end else if (m_state == ST_ACTIVE) begin
                m_wait = busy ? 0 : m_wait + 1;
                if (!cfg_enable) m_state = ST_SHUTDOWN;
            end else begin
                if (!busy) begin m_state = ST_IDLE; m_wait = 0; end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        cfg_enable = 0; cfg_mode = 0; cfg_intr_mask = 0; init_done = 0;
        busy = 0; parity_err = 0; fatal_err = 0; err_clear = 0;
    endtask

    task automatic apply_reset();
        rst_n = 0;
        model_reset();
        #2;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        cfg_enable = 1;
        release_reset();
        tick(); tick();
        apply_reset();
        n_total++;
        if (dut_vec !== 19'd0) begin
            n_bad++; $display("FAIL reset_values: got %h want %h", dut_vec, 19'd0);
        end
        clear_inputs();
        release_reset();
    endtask

    task automatic test_init_sequence();
        tick(); tick();
        cfg_mode = 4'hA; cfg_enable = 1;
        tick();
        n_total++;
        if ({state, init_start, mode_q} !== {3'd1, 1'b1, 4'hA}) begin
            n_bad++; $display("FAIL init_entry: got st=%0d is=%0d mode=%h want st=1 is=1 mode=a", state, init_start, mode_q);
        end
        cfg_mode = 4'h3;
        tick();
        n_total++;
        if ({state, init_start, mode_q} !== {3'd1, 1'b0, 4'hA}) begin
            n_bad++; $display("FAIL init_pulse_end: got st=%0d is=%0d mode=%h want st=1 is=0 mode=a", state, init_start, mode_q);
        end
        repeat (5) tick();
        init_done = 1;
        tick();
        init_done = 0;
        n_total++;
        if ({state, mode_q} !== {3'd2, 4'hA}) begin
            n_bad++; $display("FAIL init_to_active: got st=%0d mode=%h want st=2 mode=a", state, mode_q);
        end
    endtask

    task automatic test_init_timeout();
        apply_reset(); clear_inputs(); release_reset();
        cfg_enable = 1;
        tick();
        repeat (INIT_TIMEOUT - 1) tick();
        n_total++;
        if (state !== 3'd1) begin
            n_bad++; $display("FAIL init_not_yet_timeout: got st=%0d want 1", state);
        end
        tick();
        n_total++;
        if ({state, err_type, err_count, irq} !== {3'd3, 2'd2, 8'd1, 1'b1}) begin
            n_bad++; $display("FAIL init_timeout: got st=%0d et=%0d cnt=%0d irq=%0d want 3 2 1 1", state, err_type, err_count, irq);
        end
        cfg_enable = 0; err_clear = 1;
        tick();
        err_clear = 0;
        n_total++;
        if ({state, err_type, irq, err_count} !== {3'd0, 2'd0, 1'b0, 8'd1}) begin
            n_bad++; $display("FAIL timeout_clear: got st=%0d et=%0d irq=%0d cnt=%0d want 0 0 0 1", state, err_type, irq, err_count);
        end
    endtask

    task automatic test_watchdog();
        apply_reset(); clear_inputs(); release_reset();
        cfg_enable = 1; cfg_intr_mask = 1;
        tick();
        init_done = 1;
        tick();
        init_done = 0;
        repeat (WDOG_TIMEOUT - 1) tick();
        busy = 1;
        tick();
        n_total++;
        if (state !== 3'd2) begin
            n_bad++; $display("FAIL wdog_busy_rescue: got st=%0d want 2", state);
        end
        busy = 0;
        repeat (WDOG_TIMEOUT - 1) tick();
        n_total++;
        if (state !== 3'd2) begin
            n_bad++; $display("FAIL wdog_not_yet: got st=%0d want 2", state);
        end
        tick();
        n_total++;
        if ({state, err_type, irq, err_count} !== {3'd3, 2'd2, 1'b0, 8'd1}) begin
            n_bad++; $display("FAIL wdog_timeout_masked: got st=%0d et=%0d irq=%0d cnt=%0d want 3 2 0 1", state, err_type, irq, err_count);
        end
    endtask

    task automatic test_fatal_priority();
        apply_reset(); clear_inputs(); release_reset();
        cfg_enable = 1;
        tick();
        init_done = 1; busy = 1;
        tick();
        init_done = 0; parity_err = 1; fatal_err = 1;
        tick();
        parity_err = 0; fatal_err = 0;
        n_total++;
        if ({state, err_type, err_count, irq} !== {3'd3, 2'd3, 8'd1, 1'b1}) begin
            n_bad++; $display("FAIL fatal_over_parity: got st=%0d et=%0d cnt=%0d irq=%0d want 3 3 1 1", state, err_type, err_count, irq);
        end
        err_clear = 1;
        tick();
        err_clear = 0;
        n_total++;
        if ({state, err_type, irq} !== {3'd3, 2'd3, 1'b1}) begin
            n_bad++; $display("FAIL fatal_clear_ignored: got st=%0d et=%0d irq=%0d want 3 3 1", state, err_type, irq);
        end
        apply_reset();
        n_total++;
        if (dut_vec !== 19'd0) begin
            n_bad++; $display("FAIL fatal_reset_exit: got %h want %h", dut_vec, 19'd0);
        end
        clear_inputs(); release_reset();
    endtask

    task automatic test_shutdown();
        cfg_enable = 1;
        tick();
        init_done = 1; busy = 1;
        tick();
        init_done = 0; cfg_enable = 0;
        tick();
        n_total++;
        if (state !== 3'd4) begin
            n_bad++; $display("FAIL shutdown_entry: got st=%0d want 4", state);
        end
        repeat (5) tick();
        n_total++;
        if (state !== 3'd4) begin
            n_bad++; $display("FAIL shutdown_hold: got st=%0d want 4", state);
        end
        busy = 0;
        tick();
        n_total++;
        if ({state, init_start} !== {3'd0, 1'b0}) begin
            n_bad++; $display("FAIL shutdown_exit: got st=%0d is=%0d want 0 0", state, init_start);
        end
    endtask

    task automatic test_upgrade();
        apply_reset(); clear_inputs(); release_reset();
        cfg_enable = 1; cfg_intr_mask = 1;
        tick();
        parity_err = 1;
        tick();
        parity_err = 0;
        n_total++;
        if ({state, err_type, err_count, irq} !== {3'd3, 2'd1, 8'd1, 1'b0}) begin
            n_bad++; $display("FAIL parity_masked: got st=%0d et=%0d cnt=%0d irq=%0d want 3 1 1 0", state, err_type, err_count, irq);
        end
        cfg_intr_mask = 0;
        tick();
        n_total++;
        if (irq !== 1'b0) begin
            n_bad++; $display("FAIL mask_change_no_irq: got %0d want 0", irq);
        end
        fatal_err = 1;
        tick();
        fatal_err = 0;
        n_total++;
        if ({state, err_type, err_count, irq} !== {3'd3, 2'd3, 8'd1, 1'b1}) begin
            n_bad++; $display("FAIL fatal_upgrade: got st=%0d et=%0d cnt=%0d irq=%0d want 3 3 1 1", state, err_type, err_count, irq);
        end
    endtask

    task automatic test_saturation();
        apply_reset(); clear_inputs(); release_reset();
        for (int i = 0; i < 260; i++) begin
            cfg_enable = 1;
            tick();
            parity_err = 1; cfg_enable = 0;
            tick();
            parity_err = 0; err_clear = 1;
            tick();
            err_clear = 0;
            if (i == 9) begin
                n_total++;
                if (err_count !== 8'd10) begin
                    n_bad++; $display("FAIL count_mid: got %0d want 10", err_count);
                end
            end
        end
        n_total++;
        if ({state, err_count} !== {3'd0, 8'd255}) begin
            n_bad++; $display("FAIL count_saturate: got st=%0d cnt=%0d want 0 255", state, err_count);
        end
        cfg_enable = 1;
        tick();
        parity_err = 1;
        tick();
        parity_err = 0; fatal_err = 1;
        tick();
        fatal_err = 0;
        n_total++;
        if ({state, err_type, err_count} !== {3'd3, 2'd3, 8'd255}) begin
            n_bad++; $display("FAIL saturated_upgrade: got st=%0d et=%0d cnt=%0d want 3 3 255", state, err_type, err_count);
        end
    endtask

    task automatic test_random();
        apply_reset(); clear_inputs(); release_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                apply_reset();
                n_total++;
                if (dut_vec !== model_vec()) begin
                    n_bad++; $display("FAIL random_reset cyc=%0d: got %h want %h", i, dut_vec, model_vec());
                end
                release_reset();
            end else begin
                cfg_enable    = ($urandom_range(0, 9) < 8);
                cfg_mode      = 4'($urandom_range(0, 15));
                cfg_intr_mask = ($urandom_range(0, 1) == 1);
                init_done     = ($urandom_range(0, 9) == 0);
                busy          = ($urandom_range(0, 9) < 6);
                parity_err    = ($urandom_range(0, 29) == 0);
                fatal_err     = ($urandom_range(0, 99) == 0);
                err_clear     = ($urandom_range(0, 9) == 0);
                tick();
                n_total++;
                if (dut_vec !== model_vec()) begin
                    n_bad++; $display("FAIL random_step cyc=%0d: got %h want %h", i, dut_vec, model_vec());
                end
            end
        end
    endtask

    initial begin
        model_reset();
        clear_inputs();
        apply_reset();
        test_reset();
        test_init_sequence();
        test_init_timeout();
        test_watchdog();
        test_fatal_priority();
        test_shutdown();
        test_upgrade();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
